// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the multi-channel FIR MAC engine.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_OUT
  } state_t;

  localparam int RSS_W = 64;

  typedef struct packed {
    logic signed [RSS_W-1:0] data;
    logic                    sat;
  } rss_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // The accumulator must hold a full-length sum and still fit the 64-bit rounding path.
  function automatic bit acc_w_ok(input int data_w, input int coeff_w, input int acc_w,
                                  input int max_taps);
    return (acc_w >= data_w + coeff_w + $clog2(max_taps)) && (acc_w < RSS_W - 1);
  endfunction

  function automatic rss_t round_shift_sat(input logic signed [RSS_W-1:0] v,
                                           input logic [5:0] shift, input int out_w);
    rss_t                    r;
    logic signed [RSS_W-1:0] t;
    logic signed [RSS_W-1:0] hi;
    logic signed [RSS_W-1:0] lo;
    t = v;
    if (shift != 6'd0) t = t + (64'sd1 <<< (shift - 6'd1));
    t  = t >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r.sat  = 1'b0;
    r.data = t;
    if (t > hi) begin
      r.data = hi;
      r.sat  = 1'b1;
    end else if (t < lo) begin
      r.data = lo;
      r.sat  = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_mc_delay_line.sv
// Per-channel circular sample buffers with MACS combinational read ports (newest sample at k=0).
module fir_mc_delay_line
  import fir_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int MAX_TAPS = 32,
  parameter int NUM_CH   = 2,
  parameter int MACS     = 4,
  parameter int CH_W     = 1,
  parameter int K_W      = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic [CH_W-1:0]          rd_ch,
  input  logic [K_W-1:0]           rd_k    [MACS],
  output logic signed [DATA_W-1:0] rd_data [MACS]
);

  localparam int PTR_W = idx_w(MAX_TAPS);

  logic signed [DATA_W-1:0] mem_q [NUM_CH][MAX_TAPS];
  logic signed [DATA_W-1:0] mem_d [NUM_CH][MAX_TAPS];
  logic [PTR_W-1:0]         ptr_q [NUM_CH];
  logic [PTR_W-1:0]         ptr_d [NUM_CH];

  // NOTE: every always_comb output gets a full default first, so no path can leave a latch behind.
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    if (wr_en) begin
      mem_d[wr_ch][ptr_q[wr_ch]] = wr_data;
      ptr_d[wr_ch] = (int'(ptr_q[wr_ch]) == MAX_TAPS - 1) ? '0 : ptr_q[wr_ch] + 1'b1;
    end
  end

  // Newest sample sits one slot behind the write pointer; k steps further back in time.
  always_comb begin
    for (int i = 0; i < MACS; i++) begin
      rd_data[i] = mem_q[rd_ch][PTR_W'((int'(ptr_q[rd_ch]) + 2 * MAX_TAPS - 1
                                        - int'(rd_k[i])) % MAX_TAPS)];
    end
  end

  // NOTE: the buffers are reset because zero fill is visible behaviour, not just power-up hygiene;
  // state updates use <= so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      ptr_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fir_mc_mac_engine.sv
// Time-multiplexed multi-channel FIR: IDLE accepts a sample, ACCUM runs MACS taps per cycle
// then rounds/saturates, OUT holds the result until the downstream takes it.
module fir_mc_mac_engine
  import fir_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int COEFF_W  = 16,
  parameter int ACC_W    = 40,
  parameter int OUT_W    = 16,
  parameter int MAX_TAPS = 32,
  parameter int NUM_CH   = 2,
  parameter int MACS     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [idx_w(MAX_TAPS + 1)-1:0]   tap_count,
  input  logic [5:0]                       out_shift,
  input  logic                             coeff_wr_en,
  output logic                             coeff_wr_ready,
  input  logic [idx_w(MAX_TAPS)-1:0]       coeff_wr_addr,
  input  logic signed [COEFF_W-1:0]        coeff_wr_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic signed [DATA_W-1:0]         s_data,
  input  logic [idx_w(NUM_CH)-1:0]         s_ch,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic signed [OUT_W-1:0]          m_data,
  output logic [idx_w(NUM_CH)-1:0]         m_ch,
  output logic                             m_sat
);

  localparam int TAP_W = idx_w(MAX_TAPS + 1);
  localparam int CH_W  = idx_w(NUM_CH);
  localparam int K_W   = idx_w(MAX_TAPS + MACS + 1);
  localparam int P_W   = DATA_W + COEFF_W;

  state_t                   state_q, state_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic [TAP_W-1:0]         eff_q, eff_d;
  logic [5:0]               shift_q, shift_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [K_W-1:0]           base_q, base_d;
  logic                     acc_done_q, acc_done_d;
  logic signed [OUT_W-1:0]  m_data_q, m_data_d;
  logic [CH_W-1:0]          m_ch_q, m_ch_d;
  logic                     m_sat_q, m_sat_d;
  logic signed [COEFF_W-1:0] coeff_q [MAX_TAPS];
  logic signed [COEFF_W-1:0] coeff_d [MAX_TAPS];

  logic                     dl_wr_en;
  logic [K_W-1:0]           rd_k    [MACS];
  logic signed [DATA_W-1:0] rd_data [MACS];
  logic signed [P_W-1:0]    prod    [MACS];
  logic signed [ACC_W-1:0]  mac_sum;
  rss_t                     res;

  fir_mc_delay_line #(
    .DATA_W  (DATA_W),
    .MAX_TAPS(MAX_TAPS),
    .NUM_CH  (NUM_CH),
    .MACS    (MACS),
    .CH_W    (CH_W),
    .K_W     (K_W)
  ) u_delay_line (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (dl_wr_en),
    .wr_ch  (s_ch),
    .wr_data(s_data),
    .rd_ch  (ch_q),
    .rd_k   (rd_k),
    .rd_data(rd_data)
  );

  always_comb begin
    for (int i = 0; i < MACS; i++) rd_k[i] = base_q + K_W'(i);
  end

  // Taps at or beyond eff_taps contribute nothing, which also covers the partial last group.
  always_comb begin
    mac_sum = '0;
    for (int i = 0; i < MACS; i++) begin
      prod[i] = coeff_q[rd_k[i][idx_w(MAX_TAPS)-1:0]] * rd_data[i];
      if (rd_k[i] < K_W'(eff_q)) mac_sum = mac_sum + ACC_W'(prod[i]);
    end
  end

  always_comb begin
    state_d        = state_q;
    ch_d           = ch_q;
    eff_d          = eff_q;
    shift_d        = shift_q;
    acc_d          = acc_q;
    base_d         = base_q;
    acc_done_d     = acc_done_q;
    m_data_d       = m_data_q;
    m_ch_d         = m_ch_q;
    m_sat_d        = m_sat_q;
    coeff_d        = coeff_q;
    dl_wr_en       = 1'b0;
    s_ready        = 1'b0;
    coeff_wr_ready = 1'b0;
    m_valid        = 1'b0;
    res            = round_shift_sat(64'(acc_q), shift_q, OUT_W);

    unique case (state_q)
      ST_IDLE: begin
        s_ready        = 1'b1;
        coeff_wr_ready = 1'b1;
        if (coeff_wr_en && int'(coeff_wr_addr) < MAX_TAPS) coeff_d[coeff_wr_addr] = coeff_wr_data;
        if (s_valid && int'(s_ch) < NUM_CH) begin
          dl_wr_en   = 1'b1;
          ch_d       = s_ch;
          eff_d      = (int'(tap_count) > MAX_TAPS) ? TAP_W'(MAX_TAPS) : tap_count;
          shift_d    = out_shift;
          acc_d      = '0;
          base_d     = '0;
          acc_done_d = 1'b0;
          state_d    = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        // One extra ACCUM cycle registers the rounded result after the last MAC group.
        if (acc_done_q) begin
          m_data_d = res.data[OUT_W-1:0];
          m_sat_d  = res.sat;
          m_ch_d   = ch_q;
          state_d  = ST_OUT;
        end else begin
          acc_d  = acc_q + mac_sum;
          base_d = base_q + K_W'(MACS);
          if (int'(base_q) + MACS >= int'(eff_q)) acc_done_d = 1'b1;
        end
      end
      ST_OUT: begin
        m_valid = 1'b1;
        if (m_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      eff_q      <= '0;
      shift_q    <= '0;
      acc_q      <= '0;
      base_q     <= '0;
      acc_done_q <= 1'b0;
      m_data_q   <= '0;
      m_ch_q     <= '0;
      m_sat_q    <= 1'b0;
      coeff_q    <= '{default: '0};
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      eff_q      <= eff_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      base_q     <= base_d;
      acc_done_q <= acc_done_d;
      m_data_q   <= m_data_d;
      m_ch_q     <= m_ch_d;
      m_sat_q    <= m_sat_d;
      coeff_q    <= coeff_d;
    end
  end

  assign m_data = m_data_q;
  assign m_ch   = m_ch_q;
  assign m_sat  = m_sat_q;

endmodule

// File: tb/tb_fir_mc_mac_engine.sv
// Directed bench for fir_mc_mac_engine with a behavioural FIR model and per-cycle output compare.
module tb_fir_mc_mac_engine;

  localparam int DATA_W   = 16;
  localparam int COEFF_W  = 16;
  localparam int ACC_W    = 40;
  localparam int OUT_W    = 16;
  localparam int MAX_TAPS = 32;
  localparam int NUM_CH   = 2;
  localparam int MACS     = 4;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [5:0]                tap_count = '0;
  logic [5:0]                out_shift = '0;
  logic                      coeff_wr_en = 1'b0;
  logic                      coeff_wr_ready;
  logic [4:0]                coeff_wr_addr = '0;
  logic signed [COEFF_W-1:0] coeff_wr_data = '0;
  logic                      s_valid = 1'b0;
  logic                      s_ready;
  logic signed [DATA_W-1:0]  s_data = '0;
  logic [0:0]                s_ch = '0;
  logic                      m_valid;
  logic                      m_ready = 1'b1;
  logic signed [OUT_W-1:0]   m_data;
  logic [0:0]                m_ch;
  logic                      m_sat;

  always #5 clk = ~clk;

  fir_mc_mac_engine #(
    .DATA_W(DATA_W), .COEFF_W(COEFF_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
    .MAX_TAPS(MAX_TAPS), .NUM_CH(NUM_CH), .MACS(MACS)
  ) dut (
    .clk(clk), .rst(rst), .tap_count(tap_count), .out_shift(out_shift),
    .coeff_wr_en(coeff_wr_en), .coeff_wr_ready(coeff_wr_ready),
    .coeff_wr_addr(coeff_wr_addr), .coeff_wr_data(coeff_wr_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_ch(s_ch),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ch(m_ch), .m_sat(m_sat)
  );

  typedef struct {
    longint data;
    int     ch;
    bit     sat;
  } exp_t;

  exp_t   exp_q[$];
  longint h_m    [MAX_TAPS];
  longint hist_m [NUM_CH][MAX_TAPS];
  int     checks = 0;
  int     errors = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int k = 0; k < MAX_TAPS; k++) begin
      h_m[k] = 0;
      for (int c = 0; c < NUM_CH; c++) hist_m[c][k] = 0;
    end
  endtask

  // y = sum_{k<eff} h[k]*x[n-k], wrapped to ACC_W, rounded half-up, shifted, clamped.
  function automatic exp_t model(input int ch, input int taps, input int shift);
    exp_t   e;
    longint acc, hi, lo;
    int     eff;
    eff = (taps > MAX_TAPS) ? MAX_TAPS : taps;
    acc = 0;
    for (int k = 0; k < eff; k++) acc += h_m[k] * hist_m[ch][k];
    acc = (acc <<< (64 - ACC_W)) >>> (64 - ACC_W);
    if (shift > 0) acc += longint'(1) <<< (shift - 1);
    acc = acc >>> shift;
    hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    lo = -hi - 1;
    e.ch  = ch;
    e.sat = 1'b0;
    e.data = acc;
    if (acc > hi) begin e.data = hi; e.sat = 1'b1; end
    if (acc < lo) begin e.data = lo; e.sat = 1'b1; end
    return e;
  endfunction

  task automatic write_coeff(input int addr, input longint val);
    int n = 0;
    while (!coeff_wr_ready && n < 200) begin tick(); n++; end
    check("coeff_wr_ready_wait", coeff_wr_ready, 1);
    coeff_wr_en   = 1'b1;
    coeff_wr_addr = 5'(addr);
    coeff_wr_data = COEFF_W'(val);
    h_m[addr]     = val;
    tick();
    coeff_wr_en = 1'b0;
  endtask

  task automatic send_core(input int ch, input longint x, input int taps, input int shift,
                           input bit pin, input longint pin_val, input bit pin_sat,
                           input bit cw, input int cw_addr, input longint cw_data);
    exp_t e;
    int   n, eff, a;
    n = 0;
    while (!s_ready && n < 200) begin tick(); n++; end
    check("s_ready_wait", s_ready, 1);
    s_valid   = 1'b1;
    s_ch      = 1'(ch);
    s_data    = DATA_W'(x);
    tap_count = 6'(taps);
    out_shift = 6'(shift);
    if (cw) begin
      coeff_wr_en   = 1'b1;
      coeff_wr_addr = 5'(cw_addr);
      coeff_wr_data = COEFF_W'(cw_data);
      h_m[cw_addr]  = cw_data;
    end
    for (int k = MAX_TAPS - 1; k > 0; k--) hist_m[ch][k] = hist_m[ch][k-1];
    hist_m[ch][0] = x;
    e = model(ch, taps, shift);
    exp_q.push_back(e);
    if (pin) begin
      check("model_pin_data", e.data, pin_val);
      check("model_pin_sat", e.sat, pin_sat);
    end
    tick();
    s_valid     = 1'b0;
    coeff_wr_en = 1'b0;
    eff = (taps > MAX_TAPS) ? MAX_TAPS : taps;
    a   = (eff == 0) ? 1 : (eff + MACS - 1) / MACS;
    n = 0;
    while (!m_valid && n < 200) begin tick(); n++; end
    check("latency", n, a + 1);
  endtask

  task automatic send(input int ch, input longint x, input int taps, input int shift,
                      input bit pin, input longint pin_val, input bit pin_sat);
    send_core(ch, x, taps, shift, pin, pin_val, pin_sat, 1'b0, 0, 0);
  endtask

  // Output compare: every cycle m_valid is high the held output must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && m_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_m_valid", m_valid, 0);
      end else begin
        check("m_data", m_data, exp_q[0].data);
        check("m_ch", m_ch, exp_q[0].ch);
        check("m_sat", m_sat, exp_q[0].sat);
        if (m_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    repeat (3) tick();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_sat", m_sat, 0);
    check("rst_m_ch", m_ch, 0);
    rst = 1'b0;
    check("idle_s_ready", s_ready, 1);
    check("idle_coeff_wr_ready", coeff_wr_ready, 1);

    // Impulse response on channel 0.
    for (int k = 0; k < 4; k++) write_coeff(k, k + 1);
    send(0, 1, 4, 0, 1, 1, 0);
    send(0, 0, 4, 0, 1, 2, 0);
    send(0, 0, 4, 0, 1, 3, 0);
    send(0, 0, 4, 0, 1, 4, 0);
    send(0, 0, 4, 0, 1, 0, 0);

    // Interleaved channels: ch0 impulse, ch1 step of 10.
    send(0, 1, 4, 0, 1, 1, 0);
    send(1, 10, 4, 0, 1, 10, 0);
    send(0, 0, 4, 0, 1, 2, 0);
    send(1, 10, 4, 0, 1, 30, 0);
    send(0, 0, 4, 0, 1, 3, 0);
    send(1, 10, 4, 0, 1, 60, 0);
    send(0, 0, 4, 0, 1, 4, 0);
    send(1, 10, 4, 0, 1, 100, 0);
    send(1, 10, 4, 0, 1, 100, 0);

    // Coefficient write on the accept edge is seen by that sample; zero taps gives zero.
    send_core(0, 2, 4, 0, 1, 10, 0, 1'b1, 0, 5);
    send(0, 9, 0, 0, 1, 0, 0);

    // Saturation both ways.
    for (int k = 0; k < 4; k++) write_coeff(k, 32767);
    send(0, 32767, 4, 0, 1, 32767, 1);
    send(0, -32768, 4, 0, 0, 0, 0);
    send(0, -32768, 4, 0, 0, 0, 0);
    send(0, -32768, 4, 0, 0, 0, 0);
    send(0, -32768, 4, 0, 1, -32768, 1);

    // Round-half-up with shift 1.
    write_coeff(0, 3);
    send(1, 1, 1, 1, 1, 2, 0);
    send(1, -1, 1, 1, 1, -1, 0);
    send(1, 2, 1, 1, 1, 3, 0);

    // Full-length filter with backpressure; a coefficient write during OUT must be ignored.
    for (int k = 0; k < MAX_TAPS; k++) write_coeff(k, k + 1);
    m_ready = 1'b0;
    send(1, 1, 32, 0, 1, 356, 0);
    for (int i = 0; i < 5; i++) begin
      coeff_wr_en   = (i == 0);
      coeff_wr_addr = 5'd0;
      coeff_wr_data = 16'sd99;
      check("hold_m_valid", m_valid, 1);
      check("hold_s_ready", s_ready, 0);
      check("hold_coeff_wr_ready", coeff_wr_ready, 0);
      tick();
    end
    coeff_wr_en = 1'b0;
    m_ready = 1'b1;
    tick();
    check("release_s_ready", s_ready, 1);
    check("release_m_valid", m_valid, 0);
    send(0, 1, 1, 0, 1, 1, 0);
    send(0, 0, 63, 0, 0, 0, 0);

    // Reset in the middle of ACCUM.
    while (!s_ready) tick();
    s_valid   = 1'b1;
    s_ch      = 1'b0;
    s_data    = 16'sd5;
    tap_count = 6'd32;
    tick();
    s_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    clear_model();
    check("midrst_m_valid", m_valid, 0);
    check("midrst_s_ready", s_ready, 1);
    check("midrst_coeff_wr_ready", coeff_wr_ready, 1);
    check("midrst_m_data", m_data, 0);
    send(1, 7, 4, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) write_coeff(k, k + 1);
    send(0, 1, 4, 0, 1, 1, 0);
    send(0, 0, 4, 0, 1, 2, 0);
    send(0, 0, 4, 0, 1, 3, 0);
    send(0, 0, 4, 0, 1, 4, 0);

    repeat (3) tick();
    check("expect_queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
